// File: rtl/lfsr_rng_pkg.sv
// Shared definitions for the LFSR random sources: draw FSM state type and
// default maximal-length Galois feedback masks for common widths.
package lfsr_rng_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } fsm_t;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_galois_step.sv
// One step of a right-shifting Galois LFSR (purely combinational).
// Ports:
//   cur  - current LFSR state
//   nxt  - state after one step
module lfsr_galois_step
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_16)
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  // Shift out the LSB; when it was 1, fold the feedback mask back in.
  assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_rng.sv
// Galois LFSR random source with seed load, lock-up protection and a
// rejection-sampling draw engine producing values in [0, limit).
// Ports:
//   clk, reset    - clock, async active-high reset
//   enable        - free-run step request while idle
//   seed_load     - load seed_in (0 replaced by SEED) this cycle
//   seed_in       - seed value
//   req, limit    - draw request and exclusive bound (0 = any value)
//   busy          - draw in progress
//   rnd_valid     - one-cycle pulse, rnd updated
//   rnd           - drawn value, held until the next valid
//   rnd_fallback  - with rnd_valid: draw ran out of tries, rnd forced to 0
//   state         - current LFSR state
module lfsr_rng
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_16),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter int unsigned      OUT_W     = 4,
  parameter int unsigned      MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd,
  output logic             rnd_fallback,
  output logic [WIDTH-1:0] state
);

  localparam int unsigned     TRY_W    = $clog2(MAX_TRIES) + 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d, step_nxt;
  logic [OUT_W-1:0] lim_q, lim_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic             valid_q, valid_d;
  logic             fb_q, fb_d;
  logic [OUT_W-1:0] cand;
  logic             accept;

  lfsr_galois_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .cur (state_q),
    .nxt (step_nxt)
  );

  // Candidate is the low bits of the pre-step state.
  assign cand   = state_q[OUT_W-1:0];
  assign accept = (lim_q == '0) || (cand < lim_q);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= SEED;
      lim_q   <= '0;
      tries_q <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      fb_q    <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      lim_q   <= lim_d;
      tries_q <= tries_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      fb_q    <= fb_d;
    end
  end

  // Next-state: draw FSM, LFSR stepping and result capture.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    lim_d   = lim_q;
    tries_d = tries_q;
    rnd_d   = rnd_q;
    valid_d = 1'b0;
    fb_d    = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (enable) state_d = step_nxt;
        if (req && !seed_load) begin
          fsm_d   = DRAW;
          lim_d   = limit;
          tries_d = '0;
        end
      end
      DRAW: begin
        state_d = step_nxt;
        if (accept) begin
          rnd_d   = cand;
          valid_d = 1'b1;
          fsm_d   = IDLE;
        end else if (tries_q == LAST_TRY) begin
          rnd_d   = '0;
          valid_d = 1'b1;
          fb_d    = 1'b1;
          fsm_d   = IDLE;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase

    // Seed load overrides everything and aborts a draw silently.
    // A zero seed would lock the LFSR, so it is replaced by SEED.
    if (seed_load) begin
      state_d = (seed_in == '0) ? SEED : seed_in;
      fsm_d   = IDLE;
      rnd_d   = rnd_q;
      valid_d = 1'b0;
      fb_d    = 1'b0;
    end
  end

  assign busy         = (fsm_q == DRAW);
  assign rnd_valid    = valid_q;
  assign rnd          = rnd_q;
  assign rnd_fallback = fb_q;
  assign state        = state_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: directed cases plus randomized seeds,
// free-run steps and draws, checked against a transaction-level model.
module tb_lfsr_rng;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, seed_load, req;
  logic [15:0] seed_in;
  logic [3:0]  limit;
  logic        busy, rnd_valid, rnd_fallback;
  logic [3:0]  rnd;
  logic [15:0] state;

  logic        enable3, seed_load3, req3;
  logic [15:0] seed_in3;
  logic [3:0]  limit3;
  logic        busy3, rnd_valid3, rnd_fallback3;
  logic [3:0]  rnd3;
  logic [15:0] state3;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_state;

  always #5 clk = ~clk;

  lfsr_rng u_dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .req          (req),
    .limit        (limit),
    .busy         (busy),
    .rnd_valid    (rnd_valid),
    .rnd          (rnd),
    .rnd_fallback (rnd_fallback),
    .state        (state)
  );

  lfsr_rng #(.MAX_TRIES(3)) u_dut3 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable3),
    .seed_load    (seed_load3),
    .seed_in      (seed_in3),
    .req          (req3),
    .limit        (limit3),
    .busy         (busy3),
    .rnd_valid    (rnd_valid3),
    .rnd          (rnd3),
    .rnd_fallback (rnd_fallback3),
    .state        (state3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LFSR rule in plain arithmetic: halve, and xor the mask if the value was odd.
  function automatic int unsigned m_step(input int unsigned s);
    return (s / 2) ^ ((s % 2 == 1) ? 32'hB400 : 32'h0);
  endfunction

  // Outcome of a whole draw starting from state s0.
  task automatic model_draw(input logic [15:0] s0, input logic [3:0] lim, input int max_tries,
                            output logic [3:0] r, output logic fb, output int n,
                            output logic [15:0] s_end);
    int unsigned s, c;
    s = 32'(s0); r = 4'h0; fb = 1'b1; n = max_tries;
    for (int t = 0; t < max_tries; t++) begin
      c = s % 16;
      s = m_step(s);
      if (lim == 4'h0 || c < 32'(lim)) begin
        r = 4'(c); fb = 1'b0; n = t + 1;
        break;
      end
    end
    s_end = 16'(s);
  endtask

  task automatic do_seed(input logic [15:0] v);
    seed_load = 1'b1; seed_in = v;
    tick();
    seed_load = 1'b0;
    m_state = (v == 16'h0) ? 16'h0001 : v;
    check("seed_state", 32'(state), 32'(m_state));
    check("seed_busy", 32'(busy), 32'h0);
  endtask

  task automatic do_run(input int n, input logic en);
    enable = en;
    for (int i = 0; i < n; i++) begin
      tick();
      if (en) m_state = 16'(m_step(32'(m_state)));
      check("run_state", 32'(state), 32'(m_state));
    end
    enable = 1'b0;
  endtask

  // Issue a draw; enable on the accept edge and noise on req/limit while busy.
  task automatic do_draw(input logic [3:0] lim, input logic acc_en,
                         output logic [3:0] r_out, output logic [15:0] s_out);
    logic [3:0]  er;
    logic        efb;
    int          en_cyc, busy_cyc;
    logic [15:0] es;
    logic        got;
    enable = acc_en; req = 1'b1; limit = lim;
    tick();
    if (acc_en) m_state = 16'(m_step(32'(m_state)));
    model_draw(m_state, lim, 8, er, efb, en_cyc, es);
    busy_cyc = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rnd_valid) begin got = 1'b1; break; end
      if (busy) busy_cyc++;
      req = 1'($urandom_range(0, 1));
      limit = 4'($urandom_range(0, 15));
      enable = 1'($urandom_range(0, 1));
      tick();
    end
    req = 1'b0; enable = 1'b0;
    check("draw_done", 32'(got), 32'h1);
    check("draw_busy_cycles", 32'(busy_cyc), 32'(en_cyc));
    check("draw_rnd", 32'(rnd), 32'(er));
    check("draw_fallback", 32'(rnd_fallback), 32'(efb));
    check("draw_state", 32'(state), 32'(es));
    check("draw_idle", 32'(busy), 32'h0);
    m_state = es;
    tick();
    check("valid_pulse_clear", 32'(rnd_valid), 32'h0);
    check("fallback_clear", 32'(rnd_fallback), 32'h0);
    check("rnd_hold", 32'(rnd), 32'(er));
    check("idle_no_restart", 32'(busy), 32'h0);
    r_out = er; s_out = es;
  endtask

  initial begin
    logic [3:0]  r;
    logic [15:0] s;
    logic        got;
    int          bc;
    reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = 16'h0; req = 1'b0; limit = 4'h0;
    enable3 = 1'b0; seed_load3 = 1'b0; seed_in3 = 16'h0; req3 = 1'b0; limit3 = 4'h0;
    repeat (2) tick();
    check("rst_state", 32'(state), 32'h0001);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(rnd_valid), 32'h0);
    check("rst_rnd", 32'(rnd), 32'h0);
    check("rst_fallback", 32'(rnd_fallback), 32'h0);
    reset = 1'b0;
    m_state = 16'h0001;

    // Free-run from reset and hold.
    enable = 1'b1;
    tick(); check("run1", 32'(state), 32'hB400);
    tick(); check("run2", 32'(state), 32'h5A00);
    tick(); check("run3", 32'(state), 32'h2D00);
    enable = 1'b0;
    m_state = 16'h2D00;
    do_run(2, 1'b0);

    // Seed loads, including the zero-seed lock-up guard.
    do_seed(16'h0000);
    check("seed_zero", 32'(state), 32'h0001);
    do_seed(16'h0003);

    // Unbounded draw: accepted on the first candidate.
    do_draw(4'h0, 1'b0, r, s);
    check("dir_lim0_rnd", 32'(r), 32'h3);
    check("dir_lim0_state", 32'(s), 32'hB401);

    // limit=2: 3 rejected, then 1 accepted.
    do_seed(16'h0003);
    do_draw(4'h2, 1'b0, r, s);
    check("dir_lim2_rnd", 32'(r), 32'h1);

    // Seed load in the first DRAW cycle aborts the draw silently.
    do_seed(16'h0003);
    req = 1'b1; limit = 4'h2;
    tick();
    req = 1'b0;
    check("abort_busy_before", 32'(busy), 32'h1);
    seed_load = 1'b1; seed_in = 16'h0010;
    tick();
    seed_load = 1'b0;
    check("abort_valid", 32'(rnd_valid), 32'h0);
    check("abort_idle", 32'(busy), 32'h0);
    check("abort_state", 32'(state), 32'h0010);
    tick();
    check("abort_valid_later", 32'(rnd_valid), 32'h0);
    m_state = 16'h0010;

    // req together with seed_load: seed wins, req dropped.
    req = 1'b1; seed_load = 1'b1; seed_in = 16'h1234;
    tick();
    req = 1'b0; seed_load = 1'b0;
    check("reqseed_busy", 32'(busy), 32'h0);
    check("reqseed_state", 32'(state), 32'h1234);
    m_state = 16'h1234;

    // Randomized mix of seeds, free runs and draws.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: do_seed(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
        1: do_run(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        default: do_draw(($urandom_range(0, 2) == 0) ? 4'h1 : 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)), r, s);
      endcase
    end

    // MAX_TRIES=3 instance: 15, 7, 3 rejected against limit 1 -> fallback.
    seed_load3 = 1'b1; seed_in3 = 16'h000F;
    tick();
    seed_load3 = 1'b0;
    check("fb3_seed", 32'(state3), 32'h000F);
    req3 = 1'b1; limit3 = 4'h1;
    tick();
    req3 = 1'b0;
    bc = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rnd_valid3) begin got = 1'b1; break; end
      if (busy3) bc++;
      tick();
    end
    check("fb3_done", 32'(got), 32'h1);
    check("fb3_busy_cycles", 32'(bc), 32'h3);
    check("fb3_rnd", 32'(rnd3), 32'h0);
    check("fb3_fallback", 32'(rnd_fallback3), 32'h1);
    check("fb3_state", 32'(state3), 32'hC301);
    tick();
    check("fb3_pulse_clear", 32'(rnd_fallback3), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
